// File: rtl/branch_target_buffer_pkg.sv
// Shared branch-prediction types: direction counter encoding and PC geometry.
package bp_pkg;

  localparam int PC_W       = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    SNOTTAKEN = 2'b00,
    WNOTTAKEN = 2'b01,
    WTAKEN    = 2'b10,
    STAKEN    = 2'b11
  } pred_state_t;

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch-lookup and resolution-update bus between the pipeline and the BTB.
interface branch_target_buffer_if;
  import bp_pkg::*;

  logic [PC_W-1:0] fetch_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [PC_W-1:0] pred_npc;
  logic            upd_en;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            flush;
  logic [31:0]     hit_cnt;

  modport master (
    output fetch_pc, upd_en, upd_pc, upd_taken, upd_target, flush,
    input  pred_hit, pred_taken, pred_npc, hit_cnt
  );

  modport slave (
    input  fetch_pc, upd_en, upd_pc, upd_taken, upd_target, flush,
    output pred_hit, pred_taken, pred_npc, hit_cnt
  );
endinterface

// File: rtl/branch_target_buffer_sat_counter2.sv
// Next-state function of the per-entry 2-bit direction counter.
module sat_counter2
  import bp_pkg::*;
(
  input  pred_state_t state,
  input  logic        taken,
  output pred_state_t nxt
);

  // A weak state that mispredicts collapses to the strong opposite state.
  always_comb begin
    nxt = state;
    case (state)
      SNOTTAKEN: if (taken) nxt = WNOTTAKEN;
      WNOTTAKEN: nxt = taken ? STAKEN : SNOTTAKEN;
      WTAKEN:    nxt = taken ? STAKEN : SNOTTAKEN;
      STAKEN:    if (!taken) nxt = WTAKEN;
      default:   nxt = state;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: zero-latency lookup in fetch, update/allocate from resolution.
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input logic                   CLK,
  input logic                   RST,
  branch_target_buffer_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid;
  pred_state_t        ctr [ENTRIES];
  logic [PC_W-1:0]    tgt [ENTRIES];
  logic [TAG_W-1:0]   tag [ENTRIES];
  logic [31:0]        hit_cnt;

  logic [IDX_W-1:0]   f_idx, u_idx;
  logic [TAG_W-1:0]   f_tag, u_tag;
  logic               f_hit, u_hit;
  pred_state_t        ctr_nxt;

  // Word offset bits never participate in index or tag.
  logic unused_lo;
  assign unused_lo = ^{bus.fetch_pc[1:0], bus.upd_pc[1:0]};

  assign f_idx = bus.fetch_pc[IDX_W+1:2];
  assign f_tag = bus.fetch_pc[PC_W-1:IDX_W+2];
  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign u_tag = bus.upd_pc[PC_W-1:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign f_hit          = valid[f_idx] && (tag[f_idx] == f_tag);
  assign u_hit          = valid[u_idx] && (tag[u_idx] == u_tag);
  assign bus.pred_hit   = f_hit;
  assign bus.pred_taken = f_hit && ctr[f_idx][1];
  assign bus.pred_npc   = bus.pred_taken ? tgt[f_idx]
                                         : bus.fetch_pc + PC_W'(WORD_BYTES);
  assign bus.hit_cnt    = hit_cnt;

  sat_counter2 u_ctr (
    .state (ctr[u_idx]),
    .taken (bus.upd_taken),
    .nxt   (ctr_nxt)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid   <= '0;
      hit_cnt <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= SNOTTAKEN;
        tgt[i] <= '0;
        tag[i] <= '0;
      end
    end else if (bus.flush) begin
      valid <= '0;
    end else if (bus.upd_en) begin
      if (u_hit) begin
        ctr[u_idx] <= ctr_nxt;
        if (bus.upd_taken) tgt[u_idx] <= bus.upd_target;
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      end else if (bus.upd_taken) begin
        valid[u_idx] <= 1'b1;
        tag[u_idx]   <= u_tag;
        tgt[u_idx]   <= bus.upd_target;
        ctr[u_idx]   <= WTAKEN;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed scenarios plus randomized traffic checked against a behavioural BTB model.
module tb_branch_target_buffer;
  import bp_pkg::*;

  localparam int ENTRIES = 16;
  localparam int IDXB    = $clog2(ENTRIES);

  logic CLK = 1'b0;
  logic RST;
  branch_target_buffer_if bus ();

  branch_target_buffer #(.ENTRIES(ENTRIES)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model: per-slot valid/tag/target and a taken-ness level 0..3.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_lvl   [ENTRIES];
  logic [31:0] m_hits;

  function automatic int slot(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tagof(logic [31:0] pc);
    return int'(pc >> (IDXB + 2));
  endfunction

  function automatic int lvl_next(int l, bit t);
    if (t) return (l == 0) ? 1 : 3;
    else   return (l == 3) ? 2 : 0;
  endfunction

  function automatic void model_pred(input logic [31:0] pc, output bit hit,
                                     output bit tk, output logic [31:0] npc);
    int s;
    s   = slot(pc);
    hit = m_valid[s] && (m_tag[s] == tagof(pc));
    tk  = hit && (m_lvl[s] >= 2);
    npc = tk ? m_tgt[s] : pc + 32'd4;
  endfunction

  // Advance the model with the currently driven inputs, then clock the DUT.
  task automatic cycle();
    int s;
    bit h;
    if (RST) begin
      m_hits = 0;
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_lvl[i] = 0;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
    end else if (bus.upd_en) begin
      s = slot(bus.upd_pc);
      h = m_valid[s] && (m_tag[s] == tagof(bus.upd_pc));
      if (h) begin
        m_lvl[s] = lvl_next(m_lvl[s], bus.upd_taken);
        if (bus.upd_taken) m_tgt[s] = bus.upd_target;
        if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
      end else if (bus.upd_taken) begin
        m_valid[s] = 1; m_tag[s] = tagof(bus.upd_pc);
        m_tgt[s] = bus.upd_target; m_lvl[s] = 2;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.upd_en = 0; bus.upd_taken = 0; bus.flush = 0;
    bus.upd_pc = 0; bus.upd_target = 0;
  endtask

  task automatic upd(logic [31:0] pc, bit t, logic [31:0] target);
    bus.upd_en = 1; bus.upd_pc = pc; bus.upd_taken = t; bus.upd_target = target;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    RST = 1; idle(); bus.fetch_pc = 32'h100;
    cycle(); cycle();
    RST = 0; #1;
    checks++; if (bus.pred_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", bus.pred_hit); end
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", bus.pred_taken); end
    checks++; if (bus.pred_npc !== 32'h104) begin errors++; $display("FAIL reset_npc got %h exp 00000104", bus.pred_npc); end
    checks++; if (bus.hit_cnt !== 32'h0) begin errors++; $display("FAIL reset_hitcnt got %h exp 0", bus.hit_cnt); end
  endtask

  task automatic test_alloc();
    upd(32'h100, 1, 32'h200);
    bus.fetch_pc = 32'h100; #1;
    checks++; if ({bus.pred_hit, bus.pred_taken} !== 2'b11) begin errors++; $display("FAIL alloc_hit_taken got %b exp 11", {bus.pred_hit, bus.pred_taken}); end
    checks++; if (bus.pred_npc !== 32'h200) begin errors++; $display("FAIL alloc_npc got %h exp 00000200", bus.pred_npc); end
    checks++; if (bus.hit_cnt !== 32'h0) begin errors++; $display("FAIL alloc_hitcnt got %h exp 0", bus.hit_cnt); end
  endtask

  task automatic test_counter_seq();
    bit outc [4] = '{0, 1, 0, 0};
    bus.fetch_pc = 32'h100;
    for (int i = 0; i < 4; i++) begin
      upd(32'h100, outc[i], 32'h200);
      checks++; if ({bus.pred_hit, bus.pred_taken} !== 2'b10) begin errors++; $display("FAIL ctr_seq%0d got %b exp 10", i, {bus.pred_hit, bus.pred_taken}); end
      checks++; if (bus.pred_npc !== 32'h104) begin errors++; $display("FAIL ctr_seq_npc%0d got %h exp 00000104", i, bus.pred_npc); end
    end
    checks++; if (bus.hit_cnt !== 32'd4) begin errors++; $display("FAIL ctr_seq_hitcnt got %0d exp 4", bus.hit_cnt); end
    // SNT -T-> WNT (not taken) -T-> ST (taken) -NT-> WT (taken) -NT-> SNT (not taken)
    upd(32'h100, 1, 32'h220);
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_wnt got %b exp 0", bus.pred_taken); end
    upd(32'h100, 1, 32'h240);
    checks++; if (bus.pred_npc !== 32'h240) begin errors++; $display("FAIL ctr_st got %h exp 00000240", bus.pred_npc); end
    upd(32'h100, 0, 32'h0);
    checks++; if (bus.pred_npc !== 32'h240) begin errors++; $display("FAIL ctr_wt got %h exp 00000240", bus.pred_npc); end
    upd(32'h100, 0, 32'h0);
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_wt_nt got %b exp 0", bus.pred_taken); end
    checks++; if (bus.hit_cnt !== 32'd8) begin errors++; $display("FAIL ctr_hitcnt8 got %0d exp 8", bus.hit_cnt); end
  endtask

  task automatic test_alias();
    upd(32'h500, 1, 32'h600);
    bus.fetch_pc = 32'h100; #1;
    checks++; if (bus.pred_hit !== 1'b0 || bus.pred_npc !== 32'h104) begin errors++; $display("FAIL alias_old got hit=%b npc=%h exp hit=0 npc=00000104", bus.pred_hit, bus.pred_npc); end
    bus.fetch_pc = 32'h500; #1;
    checks++; if (bus.pred_hit !== 1'b1 || bus.pred_npc !== 32'h600) begin errors++; $display("FAIL alias_new got hit=%b npc=%h exp hit=1 npc=00000600", bus.pred_hit, bus.pred_npc); end
    checks++; if (bus.hit_cnt !== 32'd8) begin errors++; $display("FAIL alias_hitcnt got %0d exp 8", bus.hit_cnt); end
  endtask

  task automatic test_nt_miss();
    upd(32'h40, 0, 32'h999);
    bus.fetch_pc = 32'h40; #1;
    checks++; if (bus.pred_hit !== 1'b0 || bus.pred_npc !== 32'h44) begin errors++; $display("FAIL nt_miss got hit=%b npc=%h exp hit=0 npc=00000044", bus.pred_hit, bus.pred_npc); end
  endtask

  task automatic test_same_cycle();
    upd(32'h100, 1, 32'h200);
    bus.fetch_pc = 32'h100;
    bus.upd_en = 1; bus.upd_pc = 32'h100; bus.upd_taken = 0; #1;
    checks++; if (bus.pred_taken !== 1'b1 || bus.pred_npc !== 32'h200) begin errors++; $display("FAIL same_cycle_old got tk=%b npc=%h exp tk=1 npc=00000200", bus.pred_taken, bus.pred_npc); end
    cycle(); idle(); #1;
    checks++; if (bus.pred_hit !== 1'b1 || bus.pred_taken !== 1'b0 || bus.pred_npc !== 32'h104) begin errors++; $display("FAIL same_cycle_new got hit=%b tk=%b npc=%h exp 1 0 00000104", bus.pred_hit, bus.pred_taken, bus.pred_npc); end
  endtask

  task automatic test_flush();
    logic [31:0] hc;
    hc = bus.hit_cnt;
    checks++; if (hc !== m_hits) begin errors++; $display("FAIL pre_flush_hitcnt got %0d exp %0d", hc, m_hits); end
    bus.flush = 1; bus.upd_en = 1; bus.upd_pc = 32'h100; bus.upd_taken = 1; bus.upd_target = 32'h900;
    cycle(); idle();
    bus.fetch_pc = 32'h100; #1;
    checks++; if (bus.pred_hit !== 1'b0 || bus.pred_npc !== 32'h104) begin errors++; $display("FAIL flush_100 got hit=%b npc=%h exp hit=0 npc=00000104", bus.pred_hit, bus.pred_npc); end
    bus.fetch_pc = 32'h500; #1;
    checks++; if (bus.pred_hit !== 1'b0) begin errors++; $display("FAIL flush_500 got %b exp 0", bus.pred_hit); end
    checks++; if (bus.hit_cnt !== m_hits) begin errors++; $display("FAIL flush_hitcnt got %0d exp %0d", bus.hit_cnt, m_hits); end
  endtask

  task automatic test_wrap();
    bus.fetch_pc = 32'hFFFF_FFFC; #1;
    checks++; if (bus.pred_npc !== 32'h0) begin errors++; $display("FAIL wrap_npc got %h exp 00000000", bus.pred_npc); end
    upd(32'hFFFF_FFFC, 1, 32'h1234_5678);
    checks++; if (bus.pred_npc !== 32'h1234_5678) begin errors++; $display("FAIL wrap_alloc got %h exp 12345678", bus.pred_npc); end
  endtask

  task automatic test_random();
    bit          eh, et;
    logic [31:0] en;
    for (int n = 0; n < 600; n++) begin
      RST            = ($urandom_range(0, 199) == 0);
      bus.flush      = ($urandom_range(0, 49) == 0);
      bus.upd_en     = ($urandom_range(0, 3) != 0);
      bus.upd_pc     = {26'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom)};
      bus.upd_taken  = $urandom_range(0, 1);
      bus.upd_target = $urandom & 32'hFFFF_FFFC;
      bus.fetch_pc   = {26'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom)};
      #1;
      model_pred(bus.fetch_pc, eh, et, en);
      checks++;
      if (bus.pred_hit !== eh || bus.pred_taken !== et || bus.pred_npc !== en) begin
        errors++;
        $display("FAIL rand_pred[%0d] pc=%h got %b%b %h exp %b%b %h", n, bus.fetch_pc,
                 bus.pred_hit, bus.pred_taken, bus.pred_npc, eh, et, en);
      end
      cycle();
      checks++;
      if (bus.hit_cnt !== m_hits) begin
        errors++;
        $display("FAIL rand_hitcnt[%0d] got %0d exp %0d", n, bus.hit_cnt, m_hits);
      end
    end
    RST = 0; idle();
  endtask

  initial begin
    RST = 1; idle(); bus.fetch_pc = 0;
    test_reset();
    test_alloc();
    test_counter_seq();
    test_alias();
    test_nt_miss();
    test_same_cycle();
    test_flush();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
